// File: rtl/eca_pkg.sv
// rtl/eca_pkg.sv - shared parameters, packer state type and parity-count clamp
package eca_pkg;

  localparam int W             = 4;
  localparam int PACKET_LENGTH = 2;
  localparam int M_MAX         = 4;
  localparam int M_MIN         = 2;
  localparam int PKT_W         = W * PACKET_LENGTH;
  localparam int OUTBUF_DATA_W = PKT_W * M_MAX;
  localparam int M_W           = $clog2(M_MAX + 1);

  typedef enum logic {
    PK_EMPTY,
    PK_FILL
  } pk_state_e;

  // Illegal parity counts fall back to the widest word.
  function automatic logic [M_W-1:0] clamp_m(input logic [M_W-1:0] m);
    if (int'(m) < M_MIN || int'(m) > M_MAX) begin
      return M_W'(M_MAX);
    end
    return m;
  endfunction

endpackage

// File: rtl/eca_sync_fifo.sv
// rtl/eca_sync_fifo.sv - synchronous FIFO with registered dout loaded on pop
module eca_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = dout_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      dout_d   = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/eca_outbuf.sv
// rtl/eca_outbuf.sv - packs engine parity packets into words and serves them to the user
module eca_outbuf
  import eca_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     eca_en,
  input  logic [M_W-1:0]           m_val,
  input  logic                     eng_wr_val,
  output logic                     eng_wr_rdy,
  input  logic [PKT_W-1:0]         eng_wr_data,
  input  logic                     eng_wr_last,
  input  logic                     outbuf_rd_req,
  output logic                     outbuf_rd_data_val,
  output logic [OUTBUF_DATA_W-1:0] outbuf_rd_data,
  output logic                     outbuf_full,
  output logic                     outbuf_empty,
  output logic [CNT_W-1:0]         outbuf_count,
  output logic                     rd_underflow
);

  pk_state_e                state_q, state_d;
  logic [M_W-1:0]           slot_q, slot_d;
  logic [M_W-1:0]           m_lat_q, m_lat_d;
  logic [M_W-1:0]           m_cur;
  logic [OUTBUF_DATA_W-1:0] pack_q, pack_d;
  logic [OUTBUF_DATA_W-1:0] word;
  logic                     rd_data_val_q, rd_data_val_d;
  logic                     rd_underflow_q, rd_underflow_d;
  logic                     accept, close, pop;
  logic                     fifo_full, fifo_empty;

  // Acceptance is blocked while full even if a pop happens in the same cycle.
  assign eng_wr_rdy = eca_en && !fifo_full;
  assign accept     = eng_wr_val && eng_wr_rdy;
  assign pop        = outbuf_rd_req && !fifo_empty;

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    m_lat_d = m_lat_q;
    pack_d  = pack_q;
    m_cur   = (state_q == PK_EMPTY) ? clamp_m(m_val) : m_lat_q;
    word    = pack_q;
    word[int'(slot_q) * PKT_W +: PKT_W] = eng_wr_data;
    close   = accept && (eng_wr_last || (slot_q == m_cur - M_W'(1)));
    if (accept) begin
      if (state_q == PK_EMPTY) begin
        m_lat_d = m_cur;
      end
      if (close) begin
        state_d = PK_EMPTY;
        slot_d  = '0;
        pack_d  = '0;
      end else begin
        state_d = PK_FILL;
        slot_d  = slot_q + M_W'(1);
        pack_d  = word;
      end
    end
  end

  always_comb begin
    rd_data_val_d  = pop;
    rd_underflow_d = outbuf_rd_req && fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= PK_EMPTY;
      slot_q         <= '0;
      m_lat_q        <= M_W'(M_MAX);
      pack_q         <= '0;
      rd_data_val_q  <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      slot_q         <= slot_d;
      m_lat_q        <= m_lat_d;
      pack_q         <= pack_d;
      rd_data_val_q  <= rd_data_val_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  eca_sync_fifo #(
    .DATA_W (OUTBUF_DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (close),
    .din   (word),
    .pop   (pop),
    .dout  (outbuf_rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outbuf_count)
  );

  assign outbuf_full        = fifo_full;
  assign outbuf_empty       = fifo_empty;
  assign outbuf_rd_data_val = rd_data_val_q;
  assign rd_underflow       = rd_underflow_q;

endmodule

// File: tb/tb_eca_outbuf.sv
// tb/tb_eca_outbuf.sv - vector table, corner sequences and random run against a queue model
module tb_eca_outbuf;
  import eca_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     eca_en;
  logic [M_W-1:0]           m_val;
  logic                     eng_wr_val;
  logic                     eng_wr_rdy;
  logic [PKT_W-1:0]         eng_wr_data;
  logic                     eng_wr_last;
  logic                     outbuf_rd_req;
  logic                     outbuf_rd_data_val;
  logic [OUTBUF_DATA_W-1:0] outbuf_rd_data;
  logic                     outbuf_full;
  logic                     outbuf_empty;
  logic [CNT_W-1:0]         outbuf_count;
  logic                     rd_underflow;

  always #5 clk = ~clk;

  eca_outbuf #(.DEPTH(DEPTH)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .eca_en             (eca_en),
    .m_val              (m_val),
    .eng_wr_val         (eng_wr_val),
    .eng_wr_rdy         (eng_wr_rdy),
    .eng_wr_data        (eng_wr_data),
    .eng_wr_last        (eng_wr_last),
    .outbuf_rd_req      (outbuf_rd_req),
    .outbuf_rd_data_val (outbuf_rd_data_val),
    .outbuf_rd_data     (outbuf_rd_data),
    .outbuf_full        (outbuf_full),
    .outbuf_empty       (outbuf_empty),
    .outbuf_count       (outbuf_count),
    .rd_underflow       (rd_underflow)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue of finished words plus the packets of the open word.
  logic [31:0] mq[$];
  logic [7:0]  pk[$];
  int          cur_m;
  logic [31:0] m_rd_data;
  logic        m_rd_val;
  logic        m_uf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int legal_m(input int m);
    return (m >= M_MIN && m <= M_MAX) ? m : M_MAX;
  endfunction

  task automatic model_reset();
    mq.delete();
    pk.delete();
    cur_m     = M_MAX;
    m_rd_data = '0;
    m_rd_val  = 1'b0;
    m_uf      = 1'b0;
  endtask

  task automatic cycle(input logic en, input logic [2:0] m, input logic val,
                       input logic [7:0] d, input logic last, input logic req);
    logic        exp_rdy;
    logic        can_pop;
    logic [31:0] w;
    eca_en        = en;
    m_val         = m;
    eng_wr_val    = val;
    eng_wr_data   = d;
    eng_wr_last   = last;
    outbuf_rd_req = req;
    exp_rdy = en && (mq.size() < DEPTH);
    can_pop = (mq.size() > 0);
    #1;
    chk("rdy", 32'(eng_wr_rdy), 32'(exp_rdy));
    @(posedge clk);
    m_rd_val = req && can_pop;
    m_uf     = req && !can_pop;
    if (m_rd_val) m_rd_data = mq.pop_front();
    if (val && exp_rdy) begin
      if (pk.size() == 0) cur_m = legal_m(int'(m));
      pk.push_back(d);
      if (pk.size() == cur_m || last) begin
        w = '0;
        foreach (pk[i]) w |= 32'(pk[i]) << (8 * i);
        mq.push_back(w);
        pk.delete();
      end
    end
    #1;
    chk("rd_data_val", 32'(outbuf_rd_data_val), 32'(m_rd_val));
    chk("rd_data", outbuf_rd_data, m_rd_data);
    chk("rd_underflow", 32'(rd_underflow), 32'(m_uf));
    chk("count", 32'(outbuf_count), 32'(mq.size()));
    chk("empty", 32'(outbuf_empty), 32'(mq.size() == 0));
    chk("full", 32'(outbuf_full), 32'(mq.size() == DEPTH));
  endtask

  task automatic idle(input logic req);
    cycle(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, req);
  endtask

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #2;
    chk("async_rst_count", 32'(outbuf_count), 32'd0);
    chk("async_rst_empty", 32'(outbuf_empty), 32'd1);
    #2 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        en;
    logic [2:0]  m;
    logic        val;
    logic [7:0]  d;
    logic        last;
    logic        req;
    logic        e_val;
    logic [31:0] e_data;
    logic [2:0]  e_cnt;
    logic        e_uf;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    eca_en = 1'b0; m_val = '0; eng_wr_val = 1'b0; eng_wr_data = '0;
    eng_wr_last = 1'b0; outbuf_rd_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdy", 32'(eng_wr_rdy), 32'd0);
    chk("reset_val", 32'(outbuf_rd_data_val), 32'd0);
    chk("reset_data", outbuf_rd_data, 32'd0);
    chk("reset_full", 32'(outbuf_full), 32'd0);
    chk("reset_empty", 32'(outbuf_empty), 32'd1);
    chk("reset_count", 32'(outbuf_count), 32'd0);
    chk("reset_uf", 32'(rd_underflow), 32'd0);
    rst_n = 1'b1;

    tbl = '{
      '{1, 2, 1, 8'hA5, 0, 0, 0, 32'h00000000, 0, 0},
      '{1, 2, 1, 8'h3C, 0, 0, 0, 32'h00000000, 1, 0},
      '{1, 2, 0, 8'h00, 0, 1, 1, 32'h00003CA5, 0, 0},
      '{1, 4, 1, 8'h11, 0, 0, 0, 32'h00003CA5, 0, 0},
      '{1, 4, 1, 8'h22, 0, 0, 0, 32'h00003CA5, 0, 0},
      '{1, 4, 1, 8'h33, 0, 0, 0, 32'h00003CA5, 0, 0},
      '{1, 4, 1, 8'h44, 0, 0, 0, 32'h00003CA5, 1, 0},
      '{1, 4, 0, 8'h00, 0, 1, 1, 32'h44332211, 0, 0},
      '{1, 4, 1, 8'h55, 0, 0, 0, 32'h44332211, 0, 0},
      '{1, 4, 1, 8'h66, 1, 0, 0, 32'h44332211, 1, 0},
      '{1, 4, 0, 8'h00, 0, 1, 1, 32'h00006655, 0, 0},
      '{1, 4, 0, 8'h00, 0, 1, 0, 32'h00006655, 0, 1},
      '{1, 4, 0, 8'h00, 0, 0, 0, 32'h00006655, 0, 0}
    };
    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].en, tbl[i].m, tbl[i].val, tbl[i].d, tbl[i].last, tbl[i].req);
      chk($sformatf("tbl%0d_val", i), 32'(outbuf_rd_data_val), 32'(tbl[i].e_val));
      chk($sformatf("tbl%0d_data", i), outbuf_rd_data, tbl[i].e_data);
      chk($sformatf("tbl%0d_count", i), 32'(outbuf_count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_uf", i), 32'(rd_underflow), 32'(tbl[i].e_uf));
    end

    // Fill to DEPTH words, then hold a beat against the full FIFO.
    for (int i = 0; i < 8; i++) cycle(1'b1, 3'd2, 1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h18, 1'b0, 1'b0);
    chk("full_flag", 32'(outbuf_full), 32'd1);
    chk("full_count", 32'(outbuf_count), 32'd4);
    #1 chk("full_rdy", 32'(eng_wr_rdy), 32'd0);
    cycle(1'b1, 3'd2, 1'b1, 8'h18, 1'b0, 1'b1);
    chk("full_pop_data", outbuf_rd_data, 32'h00001110);
    chk("full_pop_count", 32'(outbuf_count), 32'd3);
    cycle(1'b1, 3'd2, 1'b1, 8'h18, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h19, 1'b0, 1'b0);
    chk("fifth_word_full", 32'(outbuf_full), 32'd1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("order_last", outbuf_rd_data, 32'h00001918);
    idle(1'b0);

    // Close a word in the same cycle as a read at count=2.
    cycle(1'b1, 3'd2, 1'b1, 8'h01, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h02, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h03, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h04, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h05, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h06, 1'b0, 1'b1);
    chk("pushpop_count", 32'(outbuf_count), 32'd2);
    chk("pushpop_data", outbuf_rd_data, 32'h00000201);
    for (int i = 0; i < 2; i++) idle(1'b1);

    // eca_en low holds the partial word; reads continue.
    cycle(1'b1, 3'd3, 1'b1, 8'h71, 1'b0, 1'b0);
    cycle(1'b0, 3'd2, 1'b1, 8'h72, 1'b0, 1'b1);
    cycle(1'b1, 3'd2, 1'b1, 8'h73, 1'b0, 1'b0);
    cycle(1'b1, 3'd2, 1'b1, 8'h74, 1'b0, 1'b0);
    idle(1'b1);
    chk("en_hold_word", outbuf_rd_data, 32'h00747371);

    // Illegal m, reset mid-word, then illegal m again clamps to 4.
    cycle(1'b1, 3'd1, 1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b1, 3'd1, 1'b1, 8'hBB, 1'b0, 1'b0);
    mid_reset();
    for (int i = 1; i <= 3; i++) cycle(1'b1, 3'd1, 1'b1, 8'(i), 1'b0, 1'b0);
    chk("clamp_no_early_close", 32'(outbuf_count), 32'd0);
    cycle(1'b1, 3'd1, 1'b1, 8'h04, 1'b0, 1'b0);
    chk("clamp_count", 32'(outbuf_count), 32'd1);
    idle(1'b1);
    chk("clamp_word", outbuf_rd_data, 32'h04030201);
    idle(1'b1);
    chk("no_stale_word", 32'(rd_underflow), 32'd1);

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0));
      if (i == 200) mid_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
